// File: rtl/multi_alarm_ctrl_pkg.sv
// Shared definitions for the multi-channel alarm controller: time packing and channel states.
package multi_alarm_ctrl_pkg;

  localparam int unsigned TIME_W   = 52;
  localparam int unsigned SEC_LSB  = 0;
  localparam int unsigned MIN_LSB  = 8;
  localparam int unsigned HOUR_LSB = 16;
  localparam int unsigned DAY_LSB  = 24;
  localparam int unsigned MON_LSB  = 32;
  localparam int unsigned YEAR_LSB = 40;

  typedef logic [1:0] ch_state_t;
  localparam ch_state_t ST_IDLE    = 2'd0;
  localparam ch_state_t ST_ARMED   = 2'd1;
  localparam ch_state_t ST_RINGING = 2'd2;
  localparam ch_state_t ST_SNOOZE  = 2'd3;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [TIME_W-1:0] pack_time(input logic [11:0] year,
                                                  input logic [7:0]  month,
                                                  input logic [7:0]  day,
                                                  input logic [7:0]  hour,
                                                  input logic [7:0]  minute,
                                                  input logic [7:0]  second);
    logic [TIME_W-1:0] t;
    t = '0;
    t[YEAR_LSB +: 12] = year;
    t[MON_LSB  +: 8]  = month;
    t[DAY_LSB  +: 8]  = day;
    t[HOUR_LSB +: 8]  = hour;
    t[MIN_LSB  +: 8]  = minute;
    t[SEC_LSB  +: 8]  = second;
    return t;
  endfunction

endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: state machine, alarm time register, second counter and sticky missed flag.
module alarm_channel
  import multi_alarm_ctrl_pkg::*;
#(
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned SNOOZE_SEC = 300
) (
  input  logic              clk1sec,
  input  logic              rst,
  input  logic [TIME_W-1:0] cur_time,
  input  logic              wr,
  input  logic [TIME_W-1:0] wr_time,
  input  logic              wr_arm,
  input  logic              ack,
  input  logic              snooze,
  output logic              ringing,
  output logic              ring_next,
  output logic              missed
);

  localparam int unsigned CNT_W = $clog2(max_u(RING_SEC, SNOOZE_SEC) + 1);
  localparam logic [CNT_W-1:0] RING_LAST   = CNT_W'(RING_SEC - 1);
  localparam logic [CNT_W-1:0] SNOOZE_LAST = CNT_W'(SNOOZE_SEC - 1);

  ch_state_t         state_q, state_d;
  logic [TIME_W-1:0] alarm_q, alarm_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              missed_q, missed_d;

  always_comb begin
    state_d  = state_q;
    alarm_d  = alarm_q;
    cnt_d    = cnt_q;
    missed_d = missed_q;
    // A write overrides whatever the channel is doing, including ack/snooze.
    if (wr) begin
      alarm_d  = wr_time;
      state_d  = wr_arm ? ST_ARMED : ST_IDLE;
      cnt_d    = '0;
      missed_d = 1'b0;
    end else begin
      case (state_q)
        ST_ARMED: begin
          if (cur_time >= alarm_q) begin
            state_d = ST_RINGING;
            cnt_d   = '0;
          end
        end
        ST_RINGING: begin
          if (ack) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (snooze) begin
            state_d = ST_SNOOZE;
            cnt_d   = '0;
          end else if (cnt_q == RING_LAST) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            missed_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_SNOOZE: begin
          if (cnt_q == SNOOZE_LAST) begin
            state_d = ST_RINGING;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk1sec or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      alarm_q  <= '0;
      cnt_q    <= '0;
      missed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      alarm_q  <= alarm_d;
      cnt_q    <= cnt_d;
      missed_q <= missed_d;
    end
  end

  assign ringing   = (state_q == ST_RINGING);
  assign ring_next = (state_d == ST_RINGING);
  assign missed    = missed_q;

endmodule

// File: rtl/multi_alarm_ctrl.sv
// Multi-channel alarm controller: write decode, active-channel priority, ack/snooze steering, LED.
module multi_alarm_ctrl
  import multi_alarm_ctrl_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned SNOOZE_SEC = 300,
  parameter int unsigned LED_W      = 8,
  localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk1sec,
  input  logic              rst,
  input  logic [TIME_W-1:0] cur_time,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [TIME_W-1:0] wr_time,
  input  logic              wr_arm,
  input  logic              ack,
  input  logic              snooze,
  output logic [NUM_CH-1:0] ringing,
  output logic              any_ring,
  output logic [CH_W-1:0]   active_ch,
  output logic [NUM_CH-1:0] missed,
  output logic [LED_W-1:0]  alarm_led
);

  logic [NUM_CH-1:0] wr_sel, ack_sel, snooze_sel, ring_next;
  logic [CH_W-1:0]   active_d, active_q;
  logic              any_ring_q;
  logic [LED_W-1:0]  led_q;
  logic              blink_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign wr_sel[i]     = wr_en && (wr_ch == CH_W'(i));
    // Only the registered active channel sees ack/snooze, and only while something rings.
    assign ack_sel[i]    = ack && any_ring_q && (active_q == CH_W'(i));
    assign snooze_sel[i] = snooze && any_ring_q && (active_q == CH_W'(i));

    alarm_channel #(
      .RING_SEC   (RING_SEC),
      .SNOOZE_SEC (SNOOZE_SEC)
    ) u_ch (
      .clk1sec   (clk1sec),
      .rst       (rst),
      .cur_time  (cur_time),
      .wr        (wr_sel[i]),
      .wr_time   (wr_time),
      .wr_arm    (wr_arm),
      .ack       (ack_sel[i]),
      .snooze    (snooze_sel[i]),
      .ringing   (ringing[i]),
      .ring_next (ring_next[i]),
      .missed    (missed[i])
    );
  end

  always_comb begin
    active_d = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ring_next[i]) active_d = CH_W'(i);
    end
  end

  always_ff @(posedge clk1sec or negedge rst) begin
    if (!rst) begin
      any_ring_q <= 1'b0;
      active_q   <= '0;
      led_q      <= '1;
      blink_q    <= 1'b0;
    end else begin
      any_ring_q <= |ring_next;
      active_q   <= active_d;
      // Blink phase restarts so the first ringing second always drives the LEDs on.
      if (|ring_next) begin
        led_q   <= blink_q ? '1 : '0;
        blink_q <= ~blink_q;
      end else begin
        led_q   <= '1;
        blink_q <= 1'b0;
      end
    end
  end

  assign any_ring  = any_ring_q;
  assign active_ch = active_q;
  assign alarm_led = led_q;

endmodule

// File: tb/tb_multi_alarm_ctrl.sv
// Self-checking bench for multi_alarm_ctrl: per-cycle behavioural model plus directed checks.
module tb_multi_alarm_ctrl;
  import multi_alarm_ctrl_pkg::*;

  localparam int NUM_CH     = 4;
  localparam int RING_SEC   = 5;
  localparam int SNOOZE_SEC = 10;

  logic              clk1sec, rst;
  logic [TIME_W-1:0] cur_time, wr_time;
  logic              wr_en, wr_arm, ack, snooze;
  logic [1:0]        wr_ch, active_ch;
  logic [3:0]        ringing, missed;
  logic              any_ring;
  logic [7:0]        alarm_led;

  multi_alarm_ctrl #(
    .NUM_CH     (NUM_CH),
    .RING_SEC   (RING_SEC),
    .SNOOZE_SEC (SNOOZE_SEC),
    .LED_W      (8)
  ) dut (
    .clk1sec   (clk1sec),
    .rst       (rst),
    .cur_time  (cur_time),
    .wr_en     (wr_en),
    .wr_ch     (wr_ch),
    .wr_time   (wr_time),
    .wr_arm    (wr_arm),
    .ack       (ack),
    .snooze    (snooze),
    .ringing   (ringing),
    .any_ring  (any_ring),
    .active_ch (active_ch),
    .missed    (missed),
    .alarm_led (alarm_led)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int now_s;

  initial begin
    clk1sec = 1'b0;
    forever #5 clk1sec = ~clk1sec;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [TIME_W-1:0] tm(input int s);
    return pack_time(12'd2024, 8'd3, 8'd1, 8'(s / 3600), 8'((s / 60) % 60), 8'(s % 60));
  endfunction

  // Model: remaining ring / snooze seconds per channel; a channel rings while ring_left > 0.
  bit                armed     [NUM_CH];
  logic [TIME_W-1:0] alm       [NUM_CH];
  int                ring_left [NUM_CH];
  int                snz_left  [NUM_CH];
  bit                m_missed  [NUM_CH];
  bit                e_any;
  int                e_act;
  int                run;

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      armed[i] = 0; alm[i] = '0; ring_left[i] = 0; snz_left[i] = 0; m_missed[i] = 0;
    end
    e_any = 0; e_act = 0; run = 0;
  endtask

  task automatic model_step();
    bit p_any;
    int p_act;
    p_any = e_any;
    p_act = e_act;
    for (int i = 0; i < NUM_CH; i++) begin
      if (wr_en && int'(wr_ch) == i) begin
        alm[i] = wr_time; armed[i] = wr_arm; ring_left[i] = 0; snz_left[i] = 0;
        m_missed[i] = 0;
      end else if (ring_left[i] > 0) begin
        if (ack && p_any && p_act == i) begin
          ring_left[i] = 0;
        end else if (snooze && p_any && p_act == i) begin
          ring_left[i] = 0; snz_left[i] = SNOOZE_SEC;
        end else begin
          ring_left[i]--;
          if (ring_left[i] == 0) m_missed[i] = 1;
        end
      end else if (snz_left[i] > 0) begin
        snz_left[i]--;
        if (snz_left[i] == 0) ring_left[i] = RING_SEC;
      end else if (armed[i] && cur_time >= alm[i]) begin
        armed[i] = 0; ring_left[i] = RING_SEC;
      end
    end
    e_any = 0;
    e_act = 0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ring_left[i] > 0) begin e_any = 1; e_act = i; end
    end
    run = e_any ? run + 1 : 0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk1sec or negedge rst);
      if (!rst) model_reset();
      else model_step();
    end
  end

  // Per-cycle compare against the model, away from the sampling edge.
  initial begin
    forever begin
      @(negedge clk1sec);
      if (rst) begin
        logic [3:0] er, em;
        logic [7:0] el;
        for (int i = 0; i < NUM_CH; i++) begin
          er[i] = (ring_left[i] > 0);
          em[i] = m_missed[i];
        end
        el = (run % 2 == 1) ? 8'h00 : 8'hFF;
        chk("cyc_ringing", 64'(ringing), 64'(er));
        chk("cyc_any_ring", 64'(any_ring), 64'(e_any));
        chk("cyc_active_ch", 64'(active_ch), 64'(e_act));
        chk("cyc_missed", 64'(missed), 64'(em));
        chk("cyc_alarm_led", 64'(alarm_led), 64'(el));
      end
    end
  end

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      cur_time = tm(now_s);
      @(negedge clk1sec);
      now_s++;
    end
  endtask

  task automatic write(input int ch, input logic [TIME_W-1:0] t, input logic arm);
    wr_en = 1'b1; wr_ch = 2'(ch); wr_time = t; wr_arm = arm;
  endtask

  task automatic pulse_ack();
    ack = 1'b1; step(1); ack = 1'b0;
  endtask

  initial begin
    rst = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_time = '0; wr_arm = 1'b0;
    ack = 1'b0; snooze = 1'b0;
    now_s = 12 * 3600;
    cur_time = tm(now_s);
    repeat (2) @(negedge clk1sec);
    chk("rst_ringing", 64'(ringing), 64'h0);
    chk("rst_any_ring", 64'(any_ring), 64'h0);
    chk("rst_active_ch", 64'(active_ch), 64'h0);
    chk("rst_missed", 64'(missed), 64'h0);
    chk("rst_led", 64'(alarm_led), 64'hFF);
    rst = 1'b1;

    // Basic ring-out of ch2 at 12:00:05
    write(2, tm(12 * 3600 + 5), 1'b1); step(1); wr_en = 1'b0;
    step(4);
    chk("s1_pre_ring", 64'(ringing), 64'h0);
    step(1);
    chk("s1_ring", 64'(ringing), 64'h4);
    chk("s1_led0", 64'(alarm_led), 64'h00);
    chk("s1_active", 64'(active_ch), 64'h2);
    step(1);
    chk("s1_led1", 64'(alarm_led), 64'hFF);
    step(3);
    chk("s1_last_sec", 64'(ringing), 64'h4);
    chk("s1_led4", 64'(alarm_led), 64'h00);
    step(1);
    chk("s1_ring_out", 64'(ringing), 64'h0);
    chk("s1_missed", 64'(missed), 64'h4);
    chk("s1_led_idle", 64'(alarm_led), 64'hFF);

    // ch0 and ch3 together, acked in priority order
    write(0, tm(now_s + 3), 1'b1); step(1);
    wr_ch = 2'd3; step(1); wr_en = 1'b0;
    step(2);
    chk("s2_both", 64'(ringing), 64'h9);
    chk("s2_act0", 64'(active_ch), 64'h0);
    pulse_ack();
    chk("s2_after_ack", 64'(ringing), 64'h8);
    chk("s2_act3", 64'(active_ch), 64'h3);
    pulse_ack();
    chk("s2_quiet", 64'(any_ring), 64'h0);

    // Snooze on ring second 2 of ch1
    write(1, tm(now_s + 1), 1'b1); step(1); wr_en = 1'b0;
    step(2);
    snooze = 1'b1; step(1); snooze = 1'b0;
    chk("s3_snoozed", 64'(ringing), 64'h0);
    step(9);
    chk("s3_snooze_end", 64'(ringing), 64'h0);
    step(1);
    chk("s3_rering", 64'(ringing), 64'h2);
    step(4);
    chk("s3_window", 64'(ringing), 64'h2);
    step(1);
    chk("s3_ring_out", 64'(missed), 64'h6);

    // ack+snooze together; then write in the same edge
    write(1, tm(now_s + 1), 1'b1); step(1); wr_en = 1'b0;
    chk("s4_missed_clr", 64'(missed), 64'h4);
    step(1);
    ack = 1'b1; snooze = 1'b1; step(1); ack = 1'b0; snooze = 1'b0;
    chk("s4_ack_wins", 64'(ringing), 64'h0);
    step(12);
    chk("s4_no_snooze", 64'(ringing), 64'h0);
    write(1, tm(now_s + 1), 1'b1); step(1); wr_en = 1'b0;
    step(1);
    ack = 1'b1; snooze = 1'b1;
    write(1, tm(now_s + 6), 1'b1); step(1);
    wr_en = 1'b0; ack = 1'b0; snooze = 1'b0;
    chk("s4_write_wins", 64'(ringing), 64'h0);
    step(5);
    chk("s4_new_time_pre", 64'(ringing), 64'h0);
    step(1);
    chk("s4_new_time", 64'(ringing), 64'h2);
    pulse_ack();

    // Past alarm and skipped second
    write(0, tm(now_s - 3600), 1'b1); step(1); wr_en = 1'b0;
    chk("s5_armed", 64'(ringing), 64'h0);
    step(1);
    chk("s5_past", 64'(ringing), 64'h1);
    pulse_ack();
    now_s = 13 * 3600 + 3;
    write(3, tm(13 * 3600 + 5), 1'b1); step(1); wr_en = 1'b0;
    now_s = 13 * 3600 + 7;
    step(1);
    chk("s5_skip", 64'(ringing), 64'h8);
    pulse_ack();

    // Reset in the middle of a snooze
    write(2, tm(now_s + 1), 1'b1); step(1); wr_en = 1'b0;
    step(1);
    snooze = 1'b1; step(1); snooze = 1'b0;
    step(3);
    #2 rst = 1'b0;
    #1;
    chk("s6_rst_ringing", 64'(ringing), 64'h0);
    chk("s6_rst_any", 64'(any_ring), 64'h0);
    chk("s6_rst_active", 64'(active_ch), 64'h0);
    chk("s6_rst_missed", 64'(missed), 64'h0);
    chk("s6_rst_led", 64'(alarm_led), 64'hFF);
    repeat (2) @(negedge clk1sec);
    rst = 1'b1;
    step(12);
    chk("s6_no_return", 64'(ringing), 64'h0);
    chk("s6_no_missed", 64'(missed), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
